// File: rtl/uart_hex_display.sv
// ---------------------------------------------------------------------------
// uart_hex_display
//
// Hex display controller for the UART debug path. It keeps a shift history
// of the last NUM_DIGITS/2 received bytes and time-multiplexes them as hex
// digits onto a common-segment, multi-anode seven-segment display.
// Digits 1:0 always show the newest byte, digits 3:2 the one before it, and
// so on. A digit whose byte slot has not been filled yet is blanked, but its
// anode is still scanned.
//
// Parameters
//   CLK_FREQ       : i_clk frequency in Hz
//   REFRESH_HZ     : full-frame refresh rate (all digits once per frame)
//   NUM_DIGITS     : digit count, even, 2..16
//   SEG_ACTIVE_LOW : 1 -> a lit segment drives 0
//   AN_ACTIVE_LOW  : 1 -> the selected anode drives 0
//
// Ports
//   i_clk          : system clock, single domain
//   i_rst          : synchronous active-high reset
//   i_rx_valid     : one-cycle strobe qualifying i_rx_byte
//   i_rx_byte      : received byte
//   i_clear        : level, empties the history and zeroes the count
//   i_hold         : level, freezes the history (incoming bytes are dropped)
//   o_segments     : {g,f,e,d,c,b,a}, registered
//   o_anodes       : one-hot digit select, registered
//   o_byte_count   : bytes accepted since reset/clear, saturating at FFFF
// ---------------------------------------------------------------------------
module uart_hex_display #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int NUM_DIGITS     = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_clear,
    input  logic                  i_hold,
    output logic [6:0]            o_segments,
    output logic [NUM_DIGITS-1:0] o_anodes,
    output logic [15:0]           o_byte_count
);

    localparam int DIV    = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
    localparam int DEPTH  = NUM_DIGITS / 2;
    localparam int DIV_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Output values with nothing lit; XOR with these applies the polarity.
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    // Illegal configurations stop elaboration.
    if (DIV < 2) begin : g_bad_div
        $error("uart_hex_display: CLK_FREQ/(REFRESH_HZ*NUM_DIGITS) must be >= 2");
    end
    if ((NUM_DIGITS < 2) || (NUM_DIGITS > 16) || ((NUM_DIGITS % 2) != 0)) begin : g_bad_digits
        $error("uart_hex_display: NUM_DIGITS must be even and in 2..16");
    end

    // Active-high hex decode, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_bytes [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [15:0]           r_count;
    logic [6:0]            r_segments;
    logic [NUM_DIGITS-1:0] r_anodes;

    logic                  w_tick;
    logic                  w_accept;
    logic [SLOT_W-1:0]     w_slot;
    logic [7:0]            w_byte;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg_lit;
    logic [NUM_DIGITS-1:0] w_an_sel;

    assign w_tick   = (r_div == DIV_LAST);
    // Priority clear > hold > valid; a byte in a reset cycle is also lost.
    assign w_accept = i_rx_valid & ~i_hold & ~i_clear & ~i_rst;

    // Digit d shows nibble d%2 of slot d/2.
    assign w_slot    = SLOT_W'(r_idx >> 1);
    assign w_byte    = r_bytes[w_slot];
    assign w_nibble  = r_idx[0] ? w_byte[7:4] : w_byte[3:0];
    assign w_seg_lit = r_valid[w_slot] ? hex_to_seg(w_nibble) : 7'h00;
    assign w_an_sel  = NUM_DIGITS'(1) << r_idx;

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values; the output registers below rely on seeing the
    // old index and history in the same cycle they are updated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div      <= '0;
            r_idx      <= '0;
            r_valid    <= '0;
            r_count    <= '0;
            r_segments <= SEG_OFF;
            r_anodes   <= AN_OFF;
        end else begin
            if (w_tick) begin
                r_div <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (i_clear) begin
                r_valid <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                for (int s = DEPTH - 1; s > 0; s--) begin
                    r_valid[s] <= r_valid[s-1];
                end
                r_valid[0] <= 1'b1;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end

            // Anode and pattern come from the same index and history, so
            // they can never disagree about which digit is shown.
            r_segments <= w_seg_lit ^ SEG_OFF;
            r_anodes   <= w_an_sel ^ AN_OFF;
        end
    end

    // NOTE: the byte storage has no reset; its contents only matter where
    // the matching valid bit is set, and leaving it out of reset keeps the
    // data path free of reset muxing.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                r_bytes[s] <= r_bytes[s-1];
            end
            r_bytes[0] <= i_rx_byte;
        end
    end

    assign o_segments   = r_segments;
    assign o_anodes     = r_anodes;
    assign o_byte_count = r_count;

endmodule

// File: tb/tb_uart_hex_display.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_display
//
// Self-checking bench for uart_hex_display with CLK_FREQ=800, REFRESH_HZ=25,
// NUM_DIGITS=4 (scan divider 8), both outputs active-low.
// A timeline model (cycles since reset -> digit, byte queue -> pattern) is
// compared with the DUT on every falling edge; directed scenarios add
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_uart_hex_display;

    localparam int CLK_FREQ   = 800;
    localparam int REFRESH_HZ = 25;
    localparam int NUM_DIGITS = 4;
    localparam int DIV        = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
    localparam int DEPTH      = NUM_DIGITS / 2;

    logic       i_clk;
    logic       i_rst;
    logic       i_rx_valid;
    logic [7:0] i_rx_byte;
    logic       i_clear;
    logic       i_hold;
    logic [6:0] o_segments;
    logic [3:0] o_anodes;
    logic [15:0] o_byte_count;

    uart_hex_display #(
        .CLK_FREQ      (CLK_FREQ),
        .REFRESH_HZ    (REFRESH_HZ),
        .NUM_DIGITS    (NUM_DIGITS),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_valid  (i_rx_valid),
        .i_rx_byte   (i_rx_byte),
        .i_clear     (i_clear),
        .i_hold      (i_hold),
        .o_segments  (o_segments),
        .o_anodes    (o_anodes),
        .o_byte_count(o_byte_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] m_hist [$];     // newest byte at index 0
    bit         m_live = 1'b0;  // set once the model has seen a reset
    int         m_since;        // rising edges since the last reset edge
    int         m_cnt;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    // Outputs after edge k (k>=1 after reset) show digit ((k-1)/DIV)%N using
    // the history as it was before that edge; the history and count then
    // take this edge's inputs.
    initial begin
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                m_live  = 1'b1;
                m_since = 0;
                m_cnt   = 0;
                m_hist.delete();
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end else if (m_live) begin
                int         d;
                logic [7:0] b;
                logic [3:0] nib;
                m_since++;
                d      = ((m_since - 1) / DIV) % NUM_DIGITS;
                exp_an = ~(4'b0001 << d);
                if ((d / 2) < m_hist.size()) begin
                    b       = m_hist[d/2];
                    nib     = (d % 2 == 1) ? b[7:4] : b[3:0];
                    exp_seg = ~hex_tbl[nib];
                end else begin
                    exp_seg = 7'h7F;
                end
                if (i_clear) begin
                    m_hist.delete();
                    m_cnt = 0;
                end else if (!i_hold && i_rx_valid) begin
                    m_hist.push_front(i_rx_byte);
                    if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge i_clk);
            if (m_live) begin
                check("model anodes",   o_anodes,     exp_an);
                check("model segments", o_segments,   exp_seg);
                check("model count",    o_byte_count, m_cnt[15:0]);
            end
        end
    end

    // ---------------- stimulus helpers (enter and leave on a negedge) -----
    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Wait (bounded) until digit d is selected, then check its pattern.
    task automatic expect_digit(input int d, input logic [6:0] seg, input string name);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << d);
        n = 0;
        while (o_anodes !== want && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        check({name, " digit scanned"}, 32'(n < 40), 32'd1);
        check(name, o_segments, seg);
    endtask

    // Count falling edges until the anodes equal pat (bounded at 50).
    task automatic hold_len(input logic [3:0] pat, output int n);
        n = 0;
        while (o_anodes !== pat && n < 50) begin
            n++;
            @(negedge i_clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        i_rst      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_byte  = 8'h00;
        i_clear    = 1'b0;
        i_hold     = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // 1: reset state and anode walk; the first digit lasts DIV+1 cycles
        // counted from the reset edge, the others DIV cycles each.
        check("reset anodes",   o_anodes,     4'hF);
        check("reset segments", o_segments,   7'h7F);
        check("reset count",    o_byte_count, 16'h0000);
        hold_len(4'b1101, n);
        check("digit0 first hold", n, DIV + 1);
        hold_len(4'b1011, n);
        check("digit1 hold", n, DIV);
        hold_len(4'b0111, n);
        check("digit2 hold", n, DIV);
        hold_len(4'b1110, n);
        check("digit3 hold", n, DIV);
        check("blank while empty", o_segments, 7'h7F);

        // 2: single byte A5
        send_byte(8'hA5);
        check("A5 count", o_byte_count, 16'd1);
        expect_digit(0, 7'h12, "A5 digit0");
        expect_digit(1, 7'h08, "A5 digit1");
        expect_digit(2, 7'h7F, "A5 digit2");
        expect_digit(3, 7'h7F, "A5 digit3");

        // 3: history overflow, A5 falls off
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hF0);
        check("3 bytes count", o_byte_count, 16'd3);
        expect_digit(3, 7'h30, "F0 3C digit3");
        expect_digit(2, 7'h46, "F0 3C digit2");
        expect_digit(1, 7'h0E, "F0 3C digit1");
        expect_digit(0, 7'h40, "F0 3C digit0");

        // 4: hold drops the byte
        i_hold = 1'b1;
        send_byte(8'h11);
        i_hold = 1'b0;
        check("hold count", o_byte_count, 16'd3);
        expect_digit(0, 7'h40, "hold digit0");
        expect_digit(1, 7'h0E, "hold digit1");
        send_byte(8'h22);
        check("22 count", o_byte_count, 16'd4);
        expect_digit(0, 7'h24, "22 digit0");
        expect_digit(1, 7'h24, "22 digit1");
        expect_digit(2, 7'h40, "22 digit2");
        expect_digit(3, 7'h0E, "22 digit3");

        // 5: clear wins over a simultaneous strobe
        i_clear = 1'b1;
        send_byte(8'h77);
        i_clear = 1'b0;
        check("clear count", o_byte_count, 16'd0);
        expect_digit(0, 7'h7F, "clear digit0");
        expect_digit(1, 7'h7F, "clear digit1");
        expect_digit(2, 7'h7F, "clear digit2");
        expect_digit(3, 7'h7F, "clear digit3");

        // 6: reset mid-scan at index 2, with a strobe in the reset cycle
        send_byte(8'h81);
        expect_digit(0, 7'h79, "81 digit0");
        expect_digit(2, 7'h7F, "pre-reset digit2");
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_byte  = 8'h99;
        do_reset();
        i_rx_valid = 1'b0;
        check("mid reset anodes",   o_anodes,     4'hF);
        check("mid reset segments", o_segments,   7'h7F);
        check("mid reset count",    o_byte_count, 16'd0);
        @(negedge i_clk);
        check("restart anodes",   o_anodes,   4'hE);
        check("restart segments", o_segments, 7'h7F);
        expect_digit(1, 7'h7F, "dropped 99 digit1");
        repeat (2 * DIV) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
